// File: rtl/snail_pkg.sv
// ============================================================================
// Module  : snail_pkg
// Brief   : Shared constants and types for the snail detector/transmitter path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package snail_pkg;

    // Detector state encodings
    localparam logic [1:0] SAD    = 2'd0;
    localparam logic [1:0] HOPE   = 2'd1;
    localparam logic [1:0] HOORAY = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/snail_tx_if.sv
// ============================================================================
// Module  : snail_tx_if
// Brief   : Word handshake and serial status bundle for snail_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface snail_tx_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             D;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;

    modport master (
        output data_in, valid_in,
        input  ready_out, D, busy, done, hits
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, D, busy, done, hits
    );

endinterface

`default_nettype wire

// File: rtl/snail_pair_count.sv
// ============================================================================
// Module  : snail_pair_count
// Brief   : Counts overlapping adjacent "11" pairs in a word (combinational).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module snail_pair_count #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         word,
    output logic [$clog2(WIDTH)-1:0] count
);

    localparam int CNT_W = $clog2(WIDTH);

    // At most WIDTH-1 pairs, which always fits in CNT_W bits
    always_comb begin
        count = '0;
        for (int i = 1; i < WIDTH; i++) begin
            if (word[i] && word[i-1]) begin
                count = count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/snail_tx.sv
// ============================================================================
// Module  : snail_tx
// Brief   : MSB-first serial pattern transmitter with zero guard gap and "11" hit count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module snail_tx
    import snail_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       _rst,
    snail_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_hits;
    logic             r_done;
    logic [CNT_W-1:0] w_pair_cnt;
    logic             w_accept;
    logic             w_enter_gap;
    logic             w_done_next;

    snail_pair_count #(
        .WIDTH (WIDTH)
    ) u_pair_count (
        .word  (bus.data_in),
        .count (w_pair_cnt)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_enter_gap  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (bus.valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (r_bit_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_enter_gap  = 1'b1;
                        w_state_next = TX_GAP;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = TX_IDLE;
                    end
                end
            end
            TX_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_done_next  = 1'b1;
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    // The shift register drains to zero after the last bit, so D is 0 in gap and idle
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_hits    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_accept) begin
                r_shift   <= bus.data_in;
                r_hits    <= w_pair_cnt;
                r_bit_cnt <= CNT_W'(WIDTH - 1);
            end else if (r_state == TX_SHIFT) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                if (r_bit_cnt != '0) begin
                    r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                end
            end else begin
                r_shift <= '0;
            end
            if (w_enter_gap) begin
                r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if ((r_state == TX_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    assign bus.ready_out = (r_state == TX_IDLE);
    assign bus.busy      = (r_state == TX_SHIFT) || (r_state == TX_GAP);
    assign bus.D         = r_shift[WIDTH-1];
    assign bus.done      = r_done;
    assign bus.hits      = r_hits;

endmodule

`default_nettype wire

// File: tb/tb_snail_tx.sv
// ============================================================================
// Module  : tb_snail_tx
// Brief   : Directed self-checking bench for snail_tx (GAP_CYCLES=2 and 0 builds).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snail_tx;

    logic clk  = 1'b0;
    logic _rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] seq [3];
    logic [7:0] cur;
    logic [7:0] w0;

    snail_tx_if #(.WIDTH(8)) bus  ();
    snail_tx_if #(.WIDTH(8)) bus0 ();

    snail_tx #(.WIDTH(8), .GAP_CYCLES(2)) dut (
        .clk  (clk),
        ._rst (_rst),
        .bus  (bus)
    );

    snail_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk  (clk),
        ._rst (_rst),
        .bus  (bus0)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_h(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the GAP_CYCLES=2 DUT idle; leaves it idle at a negedge
    task automatic send_word(input logic [7:0] w, input logic [2:0] exp_hits, input string tag);
        chk_b({tag, ":ready_pre"}, bus.ready_out, 1'b1);
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h5A;
        chk_h({tag, ":hits"}, bus.hits, exp_hits);
        for (int j = 0; j < 8; j++) begin
            chk_b($sformatf("%s:D%0d", tag, j), bus.D, w[7-j]);
            chk_b($sformatf("%s:busy%0d", tag, j), bus.busy, 1'b1);
            chk_b($sformatf("%s:done%0d", tag, j), bus.done, 1'b0);
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            chk_b($sformatf("%s:gapD%0d", tag, g), bus.D, 1'b0);
            chk_b($sformatf("%s:gapbusy%0d", tag, g), bus.busy, 1'b1);
            chk_b($sformatf("%s:gapready%0d", tag, g), bus.ready_out, 1'b0);
            @(negedge clk);
        end
        chk_b({tag, ":done"}, bus.done, 1'b1);
        chk_b({tag, ":ready_done"}, bus.ready_out, 1'b1);
        chk_b({tag, ":busy_done"}, bus.busy, 1'b0);
        chk_b({tag, ":D_done"}, bus.D, 1'b0);
        chk_h({tag, ":hits_hold"}, bus.hits, exp_hits);
        @(negedge clk);
        chk_b({tag, ":done_end"}, bus.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_in   = 8'h00;
        bus.valid_in  = 1'b0;
        bus0.data_in  = 8'h00;
        bus0.valid_in = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_b("rst:D", bus.D, 1'b0);
        chk_b("rst:done", bus.done, 1'b0);
        chk_b("rst:busy", bus.busy, 1'b0);
        chk_h("rst:hits", bus.hits, 3'd0);
        chk_b("rst:ready", bus.ready_out, 1'b1);
        _rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_b($sformatf("idle:D%0d", i), bus.D, 1'b0);
            chk_b($sformatf("idle:done%0d", i), bus.done, 1'b0);
            chk_b($sformatf("idle:busy%0d", i), bus.busy, 1'b0);
            chk_b($sformatf("idle:ready%0d", i), bus.ready_out, 1'b1);
            chk_h($sformatf("idle:hits%0d", i), bus.hits, 3'd0);
        end

        send_word(8'hB6, 3'd2, "B6");
        send_word(8'hFF, 3'd7, "FF");
        send_word(8'hAA, 3'd0, "AA");
        send_word(8'h00, 3'd0, "00");

        // Back-to-back with valid_in held high; period 11 cycles
        seq[0] = 8'hF0;
        seq[1] = 8'h0F;
        seq[2] = 8'hF0;
        bus.data_in  = seq[0];
        bus.valid_in = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cur = seq[n];
            for (int c = 1; c <= 11; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    chk_h($sformatf("b2b%0d:hits", n), bus.hits, 3'd3);
                    bus.data_in = 8'hFF;
                end
                if (c <= 8) begin
                    chk_b($sformatf("b2b%0d:D%0d", n, c), bus.D, cur[8-c]);
                end else begin
                    chk_b($sformatf("b2b%0d:D%0d", n, c), bus.D, 1'b0);
                end
                chk_b($sformatf("b2b%0d:ready%0d", n, c), bus.ready_out, c == 11);
                chk_b($sformatf("b2b%0d:done%0d", n, c), bus.done, c == 11);
                if (c == 11) begin
                    if (n < 2) bus.data_in = seq[n+1];
                    else       bus.valid_in = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk_b("b2b:done_end", bus.done, 1'b0);
        chk_b("b2b:ready_end", bus.ready_out, 1'b1);

        // Reset at the 4th bit of 8'hFF
        bus.data_in  = 8'hFF;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_b("rstmid:D_pre", bus.D, 1'b1);
        _rst = 1'b0;
        #1;
        chk_b("rstmid:D", bus.D, 1'b0);
        chk_b("rstmid:busy", bus.busy, 1'b0);
        chk_b("rstmid:done", bus.done, 1'b0);
        chk_b("rstmid:ready", bus.ready_out, 1'b1);
        chk_h("rstmid:hits", bus.hits, 3'd0);
        @(negedge clk);
        _rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk_b($sformatf("rstmid:nodone%0d", i), bus.done, 1'b0);
            chk_b($sformatf("rstmid:Dzero%0d", i), bus.D, 1'b0);
            @(negedge clk);
        end
        send_word(8'h3C, 3'd3, "post_rst");

        // GAP_CYCLES=0 build: done 9 cycles after accept
        w0 = 8'hC3;
        chk_b("gap0:ready_pre", bus0.ready_out, 1'b1);
        bus0.data_in  = w0;
        bus0.valid_in = 1'b1;
        @(negedge clk);
        bus0.valid_in = 1'b0;
        chk_h("gap0:hits", bus0.hits, 3'd2);
        for (int j = 0; j < 8; j++) begin
            chk_b($sformatf("gap0:D%0d", j), bus0.D, w0[7-j]);
            chk_b($sformatf("gap0:busy%0d", j), bus0.busy, 1'b1);
            chk_b($sformatf("gap0:done%0d", j), bus0.done, 1'b0);
            @(negedge clk);
        end
        chk_b("gap0:done", bus0.done, 1'b1);
        chk_b("gap0:ready_done", bus0.ready_out, 1'b1);
        chk_b("gap0:D_done", bus0.D, 1'b0);
        @(negedge clk);
        chk_b("gap0:done_end", bus0.done, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
